btn_events: RTL and testbench

BTN_EVENTS -- requirements
Module: btn_events

---
 rtl/btn_events.sv | 192 +++++++++++++++++++
 tb/tb_btn_events.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_events.sv
// btn_events
//   Debounces up to eight active-high push buttons. Each debounced edge
//   becomes a press or release event on a valid/ready output port.
//   Optional feature: define BTN_REPEAT_EN to compile in auto-repeat.
//   While a button stays pressed, auto-repeat emits an extra press
//   every 2^rbits cycles.
//
// Parameters
//   btns  : number of buttons (1..8)
//   bits  : debounce counter width; a change must persist 2^bits cycles
//   rbits : auto-repeat interval exponent (BTN_REPEAT_EN builds only)
//
// Ports
//   clk        : main clock
//   reset      : asynchronous, active-high, clears everything
//   btn        : raw button pins, asynchronous to clk
//   btn_stable : debounced button levels
//   evt_valid  : an event is presented
//   evt_ready  : consumer accepts the presented event
//   evt_idx    : button index of the presented event
//   evt_press  : 1 = press (or repeat), 0 = release
//   evt_ovf    : sticky, set when an event was lost
module btn_events #(
  parameter int btns  = 7,
  parameter int bits  = 19,
  parameter int rbits = 23
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [btns-1:0] btn,
  output logic [btns-1:0] btn_stable,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [2:0]      evt_idx,
  output logic            evt_press,
  output logic            evt_ovf
);

  localparam logic [bits-1:0] CNT_MAX = '1;

  if (btns < 1 || btns > 8 || bits < 1 || rbits < 1) begin : g_bad_params
    $error("btn_events: illegal parameter combination");
  end

  logic [btns-1:0] sync_meta;
  logic [btns-1:0] sync_out;
  logic [btns-1:0] sync_q;
  logic [bits-1:0] cnt [btns];
  logic [btns-1:0] toggle;
  logic [btns-1:0] rwrap;
  logic [btns-1:0] press_set;
  logic [btns-1:0] rel_set;
  logic [btns-1:0] press_pend;
  logic [btns-1:0] rel_pend;
  logic [btns-1:0] press_take;
  logic [btns-1:0] rel_take;
  logic            sel_found;
  logic [2:0]      sel_idx;
  logic            sel_press;
  logic            load;
  logic            ovf_set;

  // Two-flop synchronizer, then one retiming stage. The debounce compare
  // uses the retimed copy, so the delay from the pin to btn_stable is
  // 2^bits+2 cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      sync_out  <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= btn;
      sync_out  <= sync_meta;
      sync_q    <= sync_out;
    end
  end

  // A button flips when its counter is at terminal count and the input still differs.
  always_comb begin
    toggle = '0;
    for (int i = 0; i < btns; i++) begin
      toggle[i] = (sync_q[i] != btn_stable[i]) && (cnt[i] == CNT_MAX);
    end
  end

  // Each counter runs only while its input disagrees with the debounced
  // level. Any agreement, such as a glitch ending, restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_stable <= '0;
      for (int i = 0; i < btns; i++) cnt[i] <= '0;
    end else begin
      btn_stable <= btn_stable ^ toggle;
      for (int i = 0; i < btns; i++) begin
        if (sync_q[i] != btn_stable[i] && !toggle[i]) cnt[i] <= cnt[i] + 1'b1;
        else cnt[i] <= '0;
      end
    end
  end

`ifdef BTN_REPEAT_EN
  logic [rbits-1:0] rtimer [btns];

  // The repeat timer runs free while a button is held. Each wrap to 0 behaves like a fresh press.
  always_comb begin
    rwrap = '0;
    for (int i = 0; i < btns; i++) begin
      rwrap[i] = btn_stable[i] && (rtimer[i] == '1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < btns; i++) rtimer[i] <= '0;
    end else begin
      for (int i = 0; i < btns; i++) begin
        if (btn_stable[i]) rtimer[i] <= rtimer[i] + 1'b1;
        else rtimer[i] <= '0;
      end
    end
  end
`else
  assign rwrap = '0;
`endif

  assign press_set = (toggle & ~btn_stable) | rwrap;
  assign rel_set   = toggle & btn_stable;

  // The loop scans from the highest index down, so the last hit is the winner.
  // The winner is the lowest index, and press beats release on the same index.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_press = 1'b0;
    for (int i = btns - 1; i >= 0; i--) begin
      if (rel_pend[i]) begin
        sel_found = 1'b1;
        sel_idx   = 3'(i);
        sel_press = 1'b0;
      end
      if (press_pend[i]) begin
        sel_found = 1'b1;
        sel_idx   = 3'(i);
        sel_press = 1'b1;
      end
    end
  end

  assign load = sel_found && (!evt_valid || evt_ready);

  // One-hot mask of the pending bit that moves into the output register this cycle.
  always_comb begin
    press_take = '0;
    rel_take   = '0;
    for (int i = 0; i < btns; i++) begin
      if (load && sel_idx == 3'(i)) begin
        press_take[i] = sel_press;
        rel_take[i]   = !sel_press;
      end
    end
  end

  // An event is lost only when a bit that is already pending is set
  // again without being delivered.
  assign ovf_set = |((press_set & press_pend & ~press_take) |
                     (rel_set & rel_pend & ~rel_take));

  // Pending bits and output register. A new set wins over a
  // same-cycle delivery, so that event is kept, not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_pend <= '0;
      rel_pend   <= '0;
      evt_valid  <= 1'b0;
      evt_idx    <= '0;
      evt_press  <= 1'b0;
      evt_ovf    <= 1'b0;
    end else begin
      press_pend <= (press_pend & ~press_take) | press_set;
      rel_pend   <= (rel_pend & ~rel_take) | rel_set;
      evt_ovf    <= evt_ovf | ovf_set;
      if (load) begin
        evt_valid <= 1'b1;
        evt_idx   <= sel_idx;
        evt_press <= sel_press;
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_btn_events.sv
// tb_btn_events
//   Self-checking bench for btn_events with bits=4, rbits=6, btns=7.
//   Expected events go into exp_q when a test drives its stimulus.
//   A negedge monitor records each transfer into obs_q, and each test
//   compares the two queues.
//   The test_hold case has two variants, selected by BTN_REPEAT_EN.
module tb_btn_events;

  localparam int BTNS  = 7;
  localparam int BITS  = 4;
  localparam int RBITS = 6;
  localparam int LAT   = 2**BITS + 2;

  typedef struct {
    logic [2:0] idx;
    logic       press;
    int         cyc;
  } evt_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [BTNS-1:0] btn;
  logic [BTNS-1:0] btn_stable;
  logic            evt_valid;
  logic            evt_ready;
  logic [2:0]      evt_idx;
  logic            evt_press;
  logic            evt_ovf;

  evt_t exp_q[$];
  evt_t obs_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  btn_events #(.btns(BTNS), .bits(BITS), .rbits(RBITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn),
    .btn_stable(btn_stable),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_idx   (evt_idx),
    .evt_press (evt_press),
    .evt_ovf   (evt_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Transfer monitor: valid and ready at the negedge means the following posedge completes a transfer.
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) obs_q.push_back('{evt_idx, evt_press, cyc});
  end

  task automatic do_reset();
    reset = 1'b1;
    btn = '0;
    evt_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn = '0;
    evt_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (btn_stable !== '0) begin n_fail++; $display("[TB] FAIL reset_stable: got %b expected 0", btn_stable); end
    n_checks++;
    if (evt_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", evt_valid); end
    n_checks++;
    if ({evt_idx, evt_press, evt_ovf} !== 5'b0) begin
      n_fail++; $display("[TB] FAIL reset_outputs: got %b expected 00000", {evt_idx, evt_press, evt_ovf});
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_press_latency();
    int start;
    int rise;
    evt_t e;
    evt_t o;
    do_reset();
    @(posedge clk);
    #1 btn[2] = 1'b1;
    start = cyc;
    exp_q.push_back('{3'd2, 1'b1, 0});
    rise = -1;
    for (int k = 0; k < 40 && rise < 0; k++) begin
      @(negedge clk);
      if (btn_stable[2]) begin
        rise = cyc;
        n_checks++;
        if (evt_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL early_valid: got %b expected 0", evt_valid); end
      end
    end
    n_checks++;
    if (rise - (start + 1) !== LAT) begin
      n_fail++; $display("[TB] FAIL press_latency: got %0d expected %0d", rise - (start + 1), LAT);
    end
    @(negedge clk);
    n_checks++;
    if ({evt_valid, evt_idx, evt_press} !== 5'b1_010_1) begin
      n_fail++; $display("[TB] FAIL first_event: got %b expected 10101", {evt_valid, evt_idx, evt_press});
    end
    @(posedge clk);
    #1 evt_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("[TB] FAIL latency_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if ({o.idx, o.press} !== {e.idx, e.press}) begin
        n_fail++; $display("[TB] FAIL latency_event: got %0d/%b expected %0d/%b", o.idx, o.press, e.idx, e.press);
      end
    end
  endtask

  task automatic test_glitch();
    int lens[3] = '{10, 15, 16};
    evt_t e;
    evt_t o;
    do_reset();
    evt_ready = 1'b1;
    foreach (lens[p]) begin
      @(posedge clk);
      #1 btn[0] = 1'b1;
      if (lens[p] >= 2**BITS) begin
        exp_q.push_back('{3'd0, 1'b1, 0});
        exp_q.push_back('{3'd0, 1'b0, 0});
      end
      repeat (lens[p]) @(posedge clk);
      #1 btn[0] = 1'b0;
      repeat (45) @(posedge clk);
      #1;
      if (lens[p] < 2**BITS) begin
        n_checks++;
        if (btn_stable !== '0) begin n_fail++; $display("[TB] FAIL glitch_stable len %0d: got %b expected 0", lens[p], btn_stable); end
        n_checks++;
        if (obs_q.size() !== 0) begin n_fail++; $display("[TB] FAIL glitch_events len %0d: got %0d expected 0", lens[p], obs_q.size()); end
      end
    end
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("[TB] FAIL min_pulse_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if ({o.idx, o.press} !== {e.idx, e.press}) begin
        n_fail++; $display("[TB] FAIL min_pulse_event: got %0d/%b expected %0d/%b", o.idx, o.press, e.idx, e.press);
      end
    end
  endtask

  task automatic test_stall();
    bit seen;
    evt_t e;
    evt_t o;
    do_reset();
    @(posedge clk);
    #1 btn[1] = 1'b1;
    btn[5] = 1'b1;
    exp_q.push_back('{3'd1, 1'b1, 0});
    exp_q.push_back('{3'd5, 1'b1, 0});
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = evt_valid;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("[TB] FAIL stall_wait: got timeout expected evt_valid"); end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if ({evt_valid, evt_idx, evt_press} !== 5'b1_001_1) begin
        n_fail++; $display("[TB] FAIL stall_hold %0d: got %b expected 10011", k, {evt_valid, evt_idx, evt_press});
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 evt_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (evt_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_drain: got %b expected 0", evt_valid); end
    n_checks++;
    if (obs_q.size() !== 2 || obs_q[1].cyc - obs_q[0].cyc !== 1) begin
      n_fail++; $display("[TB] FAIL back_to_back: got %0d events expected 2 on consecutive cycles", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if ({o.idx, o.press} !== {e.idx, e.press}) begin
        n_fail++; $display("[TB] FAIL stall_event: got %0d/%b expected %0d/%b", o.idx, o.press, e.idx, e.press);
      end
    end
  endtask

  task automatic test_overflow();
    bit vals[5] = '{1, 0, 1, 0, 1};
    evt_t e;
    evt_t o;
    do_reset();
    foreach (vals[p]) begin
      @(posedge clk);
      #1 btn[3] = vals[p];
      repeat (24) @(posedge clk);
    end
    #1;
    n_checks++;
    if (evt_ovf !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_set: got %b expected 1", evt_ovf); end
    n_checks++;
    if ({evt_valid, evt_idx, evt_press} !== 5'b1_011_1) begin
      n_fail++; $display("[TB] FAIL ovf_held: got %b expected 10111", {evt_valid, evt_idx, evt_press});
    end
    // The first press sits in the output register. Later presses merge
    // into one pending press, and the releases merge into one pending
    // release. Press drains before release.
    exp_q.push_back('{3'd3, 1'b1, 0});
    exp_q.push_back('{3'd3, 1'b1, 0});
    exp_q.push_back('{3'd3, 1'b0, 0});
    evt_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (evt_ovf !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_sticky: got %b expected 1", evt_ovf); end
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("[TB] FAIL ovf_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if ({o.idx, o.press} !== {e.idx, e.press}) begin
        n_fail++; $display("[TB] FAIL ovf_event: got %0d/%b expected %0d/%b", o.idx, o.press, e.idx, e.press);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    @(posedge clk);
    #1 btn[6] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = evt_valid;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("[TB] FAIL mid_wait: got timeout expected evt_valid"); end
    #2 reset = 1'b1;
    btn = '0;
    #1;
    n_checks++;
    if ({evt_valid, btn_stable} !== '0) begin
      n_fail++; $display("[TB] FAIL async_clear: got %b expected 0", {evt_valid, btn_stable});
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    evt_ready = 1'b1;
    obs_q.delete();
    repeat (40) @(posedge clk);
    #1;
    n_checks++;
    if (obs_q.size() !== 0 || evt_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL stale_event: got %0d events expected 0", obs_q.size());
    end
  endtask

  task automatic test_held_reset();
    int start;
    int rise;
    evt_t e;
    evt_t o;
    reset = 1'b1;
    btn = '0;
    btn[6] = 1'b1;
    evt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    start = cyc;
    obs_q.delete();
    exp_q.delete();
    exp_q.push_back('{3'd6, 1'b1, 0});
    rise = -1;
    for (int k = 0; k < 40 && rise < 0; k++) begin
      @(negedge clk);
      if (btn_stable[6]) rise = cyc;
    end
    n_checks++;
    if (rise - (start + 1) !== LAT) begin
      n_fail++; $display("[TB] FAIL held_latency: got %0d expected %0d", rise - (start + 1), LAT);
    end
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("[TB] FAIL held_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if ({o.idx, o.press} !== {e.idx, e.press}) begin
        n_fail++; $display("[TB] FAIL held_event: got %0d/%b expected %0d/%b", o.idx, o.press, e.idx, e.press);
      end
    end
  endtask

  // btn[4] is held for 300 cycles with evt_ready high. With auto-repeat
  // built in, four repeats follow the first press, 64 cycles apart.
  task automatic test_hold();
    int nrep;
    evt_t e;
    evt_t o;
    do_reset();
    evt_ready = 1'b1;
    @(posedge clk);
    #1 btn[4] = 1'b1;
`ifdef BTN_REPEAT_EN
    nrep = 4;
`else
    nrep = 0;
`endif
    for (int k = 0; k <= nrep; k++) exp_q.push_back('{3'd4, 1'b1, 0});
    repeat (300) @(posedge clk);
    #1 btn[4] = 1'b0;
    exp_q.push_back('{3'd4, 1'b0, 0});
    repeat (40) @(posedge clk);
    #1;
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("[TB] FAIL hold_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < nrep && k + 1 < obs_q.size(); k++) begin
      n_checks++;
      if (obs_q[k+1].cyc - obs_q[k].cyc !== 2**RBITS) begin
        n_fail++; $display("[TB] FAIL repeat_gap %0d: got %0d expected %0d", k, obs_q[k+1].cyc - obs_q[k].cyc, 2**RBITS);
      end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if ({o.idx, o.press} !== {e.idx, e.press}) begin
        n_fail++; $display("[TB] FAIL hold_event: got %0d/%b expected %0d/%b", o.idx, o.press, e.idx, e.press);
      end
    end
  endtask

  initial begin
    $display("[TB] btn_events bench start");
    test_reset();
    test_press_latency();
    test_glitch();
    test_stall();
    test_overflow();
    test_reset_mid();
    test_held_reset();
    test_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
